// File: rtl/axis_stream_monitor.sv
// rtl/axis_stream_monitor.sv - zero-latency AXI-Stream pass-through with traffic statistics
module axis_stream_monitor #(
  parameter int C_AXIS_BYTEWIDTH = 4,
  parameter int C_COUNT_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            input_s_axis_tvalid,
  input  logic [8*C_AXIS_BYTEWIDTH-1:0]   input_s_axis_tdata,
  input  logic [C_AXIS_BYTEWIDTH-1:0]     input_s_axis_tstrb,
  input  logic                            input_s_axis_tlast,
  output logic                            input_s_axis_tready,
  output logic                            output_m_axis_tvalid,
  output logic [8*C_AXIS_BYTEWIDTH-1:0]   output_m_axis_tdata,
  output logic [C_AXIS_BYTEWIDTH-1:0]     output_m_axis_tstrb,
  output logic                            output_m_axis_tlast,
  input  logic                            output_m_axis_tready,
  input  logic                            enable,
  input  logic                            clear,
  input  logic                            snapshot,
  output logic [C_COUNT_WIDTH-1:0]        byte_count,
  output logic [C_COUNT_WIDTH-1:0]        beat_count,
  output logic [C_COUNT_WIDTH-1:0]        pkt_count,
  output logic [C_COUNT_WIDTH-1:0]        stall_count,
  output logic [C_COUNT_WIDTH-1:0]        max_pkt_bytes,
  output logic [1:0]                      mon_state,
  output logic                            overflow
);

  localparam int CW = C_COUNT_WIDTH;
  localparam int PW = $clog2(C_AXIS_BYTEWIDTH + 1);

  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_WAIT_SOP = 2'b01,
    ST_COUNT    = 2'b10
  } state_t;

  state_t        state;
  logic          in_pkt;
  logic [CW-1:0] byte_live;
  logic [CW-1:0] beat_live;
  logic [CW-1:0] pkt_live;
  logic [CW-1:0] stall_live;
  logic [CW-1:0] max_live;
  logic [CW-1:0] cur_len;

  logic [PW-1:0] strb_pop;
  logic [CW-1:0] byte_add;
  logic          beat;
  logic          stall;
  logic          qualified;
  logic          q_beat;
  logic          q_stall;
  logic [CW:0]   byte_s;
  logic [CW:0]   beat_s;
  logic [CW:0]   pkt_s;
  logic [CW:0]   stall_s;
  logic [CW:0]   len_s;
  logic          ovf_hit;

  // Pure wires: the monitor never alters or delays the stream, even in reset.
  assign output_m_axis_tvalid = input_s_axis_tvalid;
  assign output_m_axis_tdata  = input_s_axis_tdata;
  assign output_m_axis_tstrb  = input_s_axis_tstrb;
  assign output_m_axis_tlast  = input_s_axis_tlast;
  assign input_s_axis_tready  = output_m_axis_tready;

  assign mon_state = state;

  // Returns {saturated, result}; the result clamps at all-ones instead of wrapping.
  function automatic logic [CW:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CW]) begin
      return {1'b1, {CW{1'b1}}};
    end
    return s;
  endfunction

  always_comb begin
    strb_pop = '0;
    for (int i = 0; i < C_AXIS_BYTEWIDTH; i++) begin
      strb_pop = strb_pop + PW'(input_s_axis_tstrb[i]);
    end
  end

  assign byte_add = CW'(strb_pop);
  assign beat     = input_s_axis_tvalid & output_m_axis_tready;
  assign stall    = input_s_axis_tvalid & ~output_m_axis_tready;

  // WAIT_SOP counts in the very cycle it sees a packet boundary, so the SOP beat is kept.
  assign qualified = enable & ((state == ST_COUNT) | ((state == ST_WAIT_SOP) & ~in_pkt));
  assign q_beat    = qualified & beat;
  assign q_stall   = qualified & stall;

  assign byte_s  = sat_add(byte_live, byte_add);
  assign beat_s  = sat_add(beat_live, CW'(1));
  assign pkt_s   = sat_add(pkt_live, CW'(1));
  assign stall_s = sat_add(stall_live, CW'(1));
  assign len_s   = sat_add(cur_len, byte_add);

  assign ovf_hit = (q_beat & (byte_s[CW] | beat_s[CW] | len_s[CW] |
                              (input_s_axis_tlast & pkt_s[CW]))) |
                   (q_stall & stall_s[CW]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_OFF;
      in_pkt        <= 1'b0;
      byte_live     <= '0;
      beat_live     <= '0;
      pkt_live      <= '0;
      stall_live    <= '0;
      max_live      <= '0;
      cur_len       <= '0;
      overflow      <= 1'b0;
      byte_count    <= '0;
      beat_count    <= '0;
      pkt_count     <= '0;
      stall_count   <= '0;
      max_pkt_bytes <= '0;
    end else begin
      if (beat) begin
        in_pkt <= ~input_s_axis_tlast;
      end

      if (!enable) begin
        state <= ST_OFF;
      end else begin
        case (state)
          ST_WAIT_SOP: if (!in_pkt) state <= ST_COUNT;
          ST_COUNT:    state <= ST_COUNT;
          default:     state <= ST_WAIT_SOP;
        endcase
      end

      // Reports take the pre-update live values, which makes snapshot+clear atomic.
      if (snapshot) begin
        byte_count    <= byte_live;
        beat_count    <= beat_live;
        pkt_count     <= pkt_live;
        stall_count   <= stall_live;
        max_pkt_bytes <= max_live;
      end

      if (clear) begin
        byte_live  <= '0;
        beat_live  <= '0;
        pkt_live   <= '0;
        stall_live <= '0;
        max_live   <= '0;
        cur_len    <= '0;
        overflow   <= 1'b0;
      end else begin
        if (q_beat) begin
          byte_live <= byte_s[CW-1:0];
          beat_live <= beat_s[CW-1:0];
          if (input_s_axis_tlast) begin
            pkt_live <= pkt_s[CW-1:0];
            cur_len  <= '0;
            if (len_s[CW-1:0] > max_live) begin
              max_live <= len_s[CW-1:0];
            end
          end else begin
            cur_len <= len_s[CW-1:0];
          end
        end
        if (q_stall) begin
          stall_live <= stall_s[CW-1:0];
        end
        if (ovf_hit) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_monitor.sv
// tb/tb_axis_stream_monitor.sv - directed self-checking bench for axis_stream_monitor
module tb_axis_stream_monitor;

  localparam int BW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_tvalid;
  logic [8*BW-1:0] s_tdata;
  logic [BW-1:0] s_tstrb;
  logic          s_tlast;
  logic          s_tready;
  logic          m_tvalid;
  logic [8*BW-1:0] m_tdata;
  logic [BW-1:0] m_tstrb;
  logic          m_tlast;
  logic          m_tready;
  logic          enable;
  logic          clear;
  logic          snapshot;
  logic [CW-1:0] byte_count;
  logic [CW-1:0] beat_count;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] max_pkt_bytes;
  logic [1:0]    mon_state;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  axis_stream_monitor #(
    .C_AXIS_BYTEWIDTH(BW),
    .C_COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .input_s_axis_tvalid(s_tvalid),
    .input_s_axis_tdata(s_tdata),
    .input_s_axis_tstrb(s_tstrb),
    .input_s_axis_tlast(s_tlast),
    .input_s_axis_tready(s_tready),
    .output_m_axis_tvalid(m_tvalid),
    .output_m_axis_tdata(m_tdata),
    .output_m_axis_tstrb(m_tstrb),
    .output_m_axis_tlast(m_tlast),
    .output_m_axis_tready(m_tready),
    .enable(enable),
    .clear(clear),
    .snapshot(snapshot),
    .byte_count(byte_count),
    .beat_count(beat_count),
    .pkt_count(pkt_count),
    .stall_count(stall_count),
    .max_pkt_bytes(max_pkt_bytes),
    .mon_state(mon_state),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] strb, input logic last);
    s_tvalid = 1'b1;
    s_tstrb  = strb;
    s_tlast  = last;
    s_tdata  = $urandom;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic snap();
    snapshot = 1'b1;
    step();
    snapshot = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    enable   = 1'b0;
    clear    = 1'b0;
    snapshot = 1'b0;
    step();
    step();
    check("rst_byte", 64'(byte_count), 64'h0);
    check("rst_state", 64'(mon_state), 64'h0);
    check("rst_ovf", 64'(overflow), 64'h0);

    // 3-beat packet F,F,3 while enabled and idle
    reset  = 1'b0;
    enable = 1'b1;
    step();
    step();
    check("t1_state", 64'(mon_state), 64'h2);
    send(4'hF, 1'b0);
    send(4'hF, 1'b0);
    send(4'h3, 1'b1);
    snap();
    check("t1_byte", 64'(byte_count), 64'd10);
    check("t1_beat", 64'(beat_count), 64'd3);
    check("t1_pkt", 64'(pkt_count), 64'd1);
    check("t1_max", 64'(max_pkt_bytes), 64'd10);
    check("t1_stall", 64'(stall_count), 64'd0);

    // enable rises mid-packet: tail of that packet must be ignored
    enable = 1'b0;
    do_clear();
    send(4'hF, 1'b0);
    send(4'hF, 1'b0);
    enable = 1'b1;
    send(4'hF, 1'b0);
    check("t2_wait_a", 64'(mon_state), 64'h1);
    send(4'hF, 1'b1);
    check("t2_wait_b", 64'(mon_state), 64'h1);
    step();
    check("t2_count", 64'(mon_state), 64'h2);
    send(4'hF, 1'b0);
    send(4'hF, 1'b1);
    snap();
    check("t2_beat", 64'(beat_count), 64'd2);
    check("t2_byte", 64'(byte_count), 64'd8);
    check("t2_pkt", 64'(pkt_count), 64'd1);

    // 5 stall cycles then one accepted beat
    do_clear();
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    s_tstrb  = 4'hF;
    s_tdata  = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      m_tready = 1'b0;
      #1;
      check("t3_rdy_lo", 64'(s_tready), 64'h0);
      step();
    end
    m_tready = 1'b1;
    #1;
    check("t3_rdy_hi", 64'(s_tready), 64'h1);
    check("t3_data", 64'(m_tdata), 64'hDEADBEEF);
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    snap();
    check("t3_stall", 64'(stall_count), 64'd5);
    check("t3_beat", 64'(beat_count), 64'd1);

    // atomic snapshot+clear with a beat in the same cycle
    do_clear();
    for (int i = 0; i < 7; i++) send(4'hF, 1'b1);
    snapshot = 1'b1;
    clear    = 1'b1;
    send(4'hF, 1'b1);
    snapshot = 1'b0;
    clear    = 1'b0;
    check("t4_rc_beat", 64'(beat_count), 64'd7);
    snap();
    check("t4_after_beat", 64'(beat_count), 64'd0);
    check("t4_after_byte", 64'(byte_count), 64'd0);

    // saturation at 16 bits
    do_clear();
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    s_tstrb  = 4'h1;
    m_tready = 1'b1;
    repeat (65537) step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("t5_ovf", 64'(overflow), 64'h1);
    snap();
    check("t5_beat", 64'(beat_count), 64'hFFFF);
    check("t5_pkt", 64'(pkt_count), 64'hFFFF);
    check("t5_byte", 64'(byte_count), 64'hFFFF);
    do_clear();
    check("t5_ovf_clr", 64'(overflow), 64'h0);
    snap();
    check("t5_beat_clr", 64'(beat_count), 64'h0);

    // reset in the middle of a packet
    do_clear();
    send(4'hF, 1'b0);
    send(4'hF, 1'b0);
    snap();
    check("t6_pre_beat", 64'(beat_count), 64'd2);
    reset    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'hA5A55A5A;
    #1;
    check("t6_pass", 64'(m_tdata), 64'hA5A55A5A);
    step();
    s_tvalid = 1'b0;
    check("t6_beat", 64'(beat_count), 64'h0);
    check("t6_byte", 64'(byte_count), 64'h0);
    check("t6_max", 64'(max_pkt_bytes), 64'h0);
    check("t6_state", 64'(mon_state), 64'h0);
    check("t6_ovf", 64'(overflow), 64'h0);
    reset = 1'b0;
    step();
    send(4'hF, 1'b1);
    snap();
    check("t6_sop_beat", 64'(beat_count), 64'd1);
    check("t6_sop_pkt", 64'(pkt_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_stream_monitor.md
AXIS_STREAM_MONITOR -- requirements
Module: axis_stream_monitor

Interface
REQ-001 SHALL have parameter C_AXIS_BYTEWIDTH, default 4, stream width in bytes, legal 1..64.
REQ-002 SHALL have parameter C_COUNT_WIDTH, default 32, width of every counter and report register, legal 16..64.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have input_s_axis_tvalid/tdata/tstrb/tlast  input  1/8*BW/BW/1  upstream stream.
REQ-006 SHALL have input_s_axis_tready  output  1  upstream ready.
REQ-007 SHALL have output_m_axis_tvalid/tdata/tstrb/tlast  output  1/8*BW/BW/1  downstream stream.
REQ-008 SHALL have output_m_axis_tready  input  1  downstream ready.
REQ-009 SHALL have enable  input  1  arms monitoring (level).
REQ-010 SHALL have clear  input  1  single-cycle zeroing of live counters.
REQ-011 SHALL have snapshot  input  1  single-cycle copy of live counters to report outputs.
REQ-012 SHALL have byte_count, beat_count, pkt_count, stall_count, max_pkt_bytes  output  C_COUNT_WIDTH each  snapshot report registers.
REQ-013 SHALL have mon_state  output  2  current FSM state; overflow  output  1  sticky saturation flag (live).

Function
REQ-014 SHALL pass tvalid, tdata, tstrb, tlast downstream and tready upstream combinationally, zero latency, unmodified, in every state including reset.
REQ-015 SHALL define beat = input_s_axis_tvalid & output_m_axis_tready; stall = tvalid & ~tready.
REQ-016 SHALL keep in_pkt flag: set on beat with tlast=0, cleared on beat with tlast=1, updated in all FSM states.
REQ-017 SHALL implement FSM OFF(00), WAIT_SOP(01), COUNT(10); 11 unreachable, decodes to OFF.
REQ-018 SHALL transition OFF->WAIT_SOP when enable=1; any state->OFF when enable=0 (that cycle not counted).
REQ-019 SHALL transition WAIT_SOP->COUNT in the cycle in_pkt=0; that cycle is count-qualified (no SOP beat lost).
REQ-020 SHALL count only in qualified cycles: COUNT, or WAIT_SOP with in_pkt=0, with enable=1.
REQ-021 SHALL per qualified beat add popcount(tstrb) to live byte_count, 1 to beat_count, 1 to pkt_count if tlast.
REQ-022 SHALL per qualified stall cycle add 1 to live stall_count.
REQ-023 SHALL accumulate cur_len += popcount(tstrb) per qualified beat; on tlast compare cur_len+popcount against live max and keep larger; cur_len then zeroed.
REQ-024 SHALL saturate every live counter and cur_len at all-ones, never wrap, and set overflow on any saturating increment.
REQ-025 SHALL on clear zero all live counters, cur_len and overflow; clear wins over same-cycle increment; FSM and in_pkt unaffected.
REQ-026 SHALL on snapshot load report registers with live values as held before that edge's update; reports otherwise hold.
REQ-027 SHALL on snapshot+clear same cycle capture pre-clear values and zero live (atomic read-and-clear).
REQ-028 SHALL treat tstrb=0 beat as counted beat with 0 bytes.

Reset
REQ-029 SHALL on reset=1 zero all live counters, reports, cur_len, in_pkt, overflow; FSM to OFF; reset dominates enable/clear/snapshot.
REQ-030 SHALL on reset mid-packet restart with in_pkt=0, so first post-reset beat is treated as SOP.

Verification
REQ-031 BW=4, enable=1 idle, 3-beat packet tstrb F,F,3, ready=1, snapshot -> byte 10, beat 3, pkt 1, max 10, stall 0.
REQ-032 enable rises after beat 2 of 4-beat packet, then 2-beat packet tstrb F,F -> beat 2, byte 8, pkt 1; mon_state 01 then 10.
REQ-033 tvalid=1, tready=0 for 5 cycles then 1 beat tlast -> stall 5, beat 1, tready mirrors output_m_axis_tready each cycle.
REQ-034 C_COUNT_WIDTH=16, 65537 single-beat packets -> beat_count 0xFFFF, overflow=1; clear -> overflow=0, live counts 0.
REQ-035 snapshot+clear with live beat 7, beat arriving same cycle -> report beat 7, next snapshot with no traffic -> 0.
REQ-036 reset asserted mid-packet, counters nonzero -> all outputs 0, mon_state 00, data still passes through.
